audio_out_stage: RTL

AUDIO_OUT_STAGE -- requirements
Module: audio_out_stage

---
 rtl/audio_out_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/audio_out_stage.sv
// Audio output stage: sample-strobe detection, soft-start/mute gain ramp,
// gain multiply, rounding and saturation to the 10-bit PWM word, and a
// clip indicator that holds for a number of samples after saturation.
//
// Pipeline: strobe cycle -> stage 1 (capture, ramp) -> stage 2 (multiply)
// -> stage 3 (round, saturate). out_valid is a one-cycle pulse in the
// cycle music_data takes its new value; there is no back-pressure, the
// consumer must take each word on the cycle out_valid is high.
module audio_out_stage #(
   parameter int CLIP_HOLD = 4800,
   parameter int RAMP_STEP = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               sample_clk,
   input  logic signed [15:0] audio_in,
   input  logic [3:0]         volume,
   input  logic               mute,
   output logic signed [9:0]  music_data,
   output logic               out_valid,
   output logic               clip,
   output logic [4:0]         gain_now
);

   localparam int            CW       = (CLIP_HOLD < 2) ? 1 : $clog2(CLIP_HOLD + 1);
   localparam logic [CW-1:0] HOLD     = CW'(CLIP_HOLD);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [7:0]    STEP     = 8'(RAMP_STEP);
   localparam logic [4:0]    GAIN_MAX = 5'd16;

   // sample clock history and strobe
   logic sc_q;
   logic strobe;

   // stage 1
   logic signed [15:0] s1_audio;
   logic               s1_valid;
   logic [4:0]         gain;
   logic [4:0]         target;
   logic [4:0]         gain_next;
   logic [7:0]         gain_up;
   logic [7:0]         gain_floor;

   // stage 2
   logic signed [20:0] product;
   logic signed [16:0] scaled_d;
   logic signed [16:0] scaled;
   logic               s2_valid;

   // stage 3
   logic signed [17:0] rounded_sum;
   logic signed [17:0] rounded;
   logic               sat_hi;
   logic               sat_lo;
   logic               sat;
   logic signed [9:0]  music_next;
   logic [CW-1:0]      clip_cnt;

   // Remember the previous sample_clk level so a rising edge can be seen.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sc_q <= 1'b0;
      end else begin
         sc_q <= sample_clk;
      end
   end

   assign strobe = sample_clk & ~sc_q;

   // Ramp target: mute wins over volume; full volume maps to unity gain 16.
   always_comb begin
      target = 5'd0;
      if (mute) begin
         target = 5'd0;
      end else if (volume == 4'd15) begin
         target = GAIN_MAX;
      end else begin
         target = {1'b0, volume};
      end
   end

   // Next gain moves at most one step toward target and never overshoots it,
   // so a retarget mid-ramp simply reverses or continues without a jump.
   always_comb begin
      gain_up    = {3'b000, gain} + STEP;
      gain_floor = {3'b000, target} + STEP;
      gain_next  = gain;
      if (gain < target) begin
         if (gain_up >= {3'b000, target}) begin
            gain_next = target;
         end else begin
            gain_next = gain_up[4:0];
         end
      end else if (gain > target) begin
         if ({3'b000, gain} <= gain_floor) begin
            gain_next = target;
         end else begin
            gain_next = gain - STEP[4:0];
         end
      end
   end

   // Stage 1: capture the sample and advance the ramp once per strobe.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_audio <= '0;
         s1_valid <= 1'b0;
         gain     <= '0;
      end else begin
         s1_valid <= strobe;
         if (strobe) begin
            s1_audio <= audio_in;
            gain     <= gain_next;
         end
      end
   end

   // Gain is 0..16, so the product is at most 2^19 in magnitude and fits
   // 21 signed bits; after the >>>4 the result always fits 17 bits.
   assign product  = 21'(s1_audio) * 21'($signed({1'b0, gain}));
   assign scaled_d = 17'(product >>> 4);

   // Stage 2: register the gain-scaled sample.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scaled   <= '0;
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            scaled <= scaled_d;
         end
      end
   end

   // Round to nearest (half up) while dropping 6 bits, then clamp to 10 bits.
   always_comb begin
      rounded_sum = 18'(scaled) + 18'sd32;
      rounded     = rounded_sum >>> 6;
      sat_hi      = (rounded > 18'sd511);
      sat_lo      = (rounded < -18'sd512);
      sat         = sat_hi | sat_lo;
      music_next  = rounded[9:0];
      if (sat_hi) begin
         music_next = 10'sd511;
      end else if (sat_lo) begin
         music_next = -10'sd512;
      end
   end

   // Stage 3: update the output word and pulse out_valid; hold otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         music_data <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            music_data <= music_next;
         end
      end
   end

   // Clip hold counter: reload on saturation, count down on clean samples.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clip_cnt <= '0;
      end else if (s2_valid) begin
         if (sat) begin
            clip_cnt <= HOLD;
         end else if (clip_cnt != '0) begin
            clip_cnt <= clip_cnt - CNT_ONE;
         end
      end
   end

   assign clip     = (clip_cnt != '0);
   assign gain_now = gain;

endmodule
